// File: rtl/vblank_access_scheduler_pkg.sv
// Shared video-timing constants and scheduler state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vblank_access_scheduler_pkg;

    // 800x600 @ 60 Hz timing, shared with the video output stage.
    localparam logic [9:0]  V_VISIBLE_LINES  = 10'd600;
    localparam logic [9:0]  V_TOTAL_LINES    = 10'd628;
    localparam logic [10:0] H_VISIBLE_PIXELS = 11'd800;
    localparam logic [10:0] H_TOTAL_PIXELS   = 11'd1056;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_ARB     = 2'd1,
        ST_GRANTED = 2'd2
    } sched_state_t;

endpackage

// File: rtl/vblank_access_scheduler_picker.sv
// Round-robin picker: first set bit of eligible at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; ports are eligible, ptr in, one-hot winner and valid out.
module round_robin_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic          valid
);

    localparam int SW = PW + 1;

    logic [SW-1:0] sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            // ptr < N and k < N, so a single subtraction gives the modulo.
            sum = {1'b0, ptr} + SW'(k);
            if (sum >= SW'(N)) begin
                sum = sum - SW'(N);
            end
            idx = sum[PW-1:0];
            if (!found && eligible[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    assign valid = |eligible;

endmodule

// File: rtl/vblank_access_scheduler.sv
// Grants exclusive game-state access, one requester at a time, only in vblank.
// Latency: WINDOW_OPEN lags Y_PIXEL by 1 cycle; GRANT follows ARB by 1 cycle.
// Backpressure: one grant per requester per frame; holder releases via DONE.
// Ports: CLK/RESET, Y_PIXEL/FRAME_START from video timing, REQ/DONE in,
//        GRANT/BUSY/WINDOW_OPEN/OVERRUN/MISSED registered out.
module vblank_access_scheduler
    import vblank_access_scheduler_pkg::*;
#(
    parameter int         NUM_REQ          = 4,
    parameter logic [9:0] VISIBLE_END_LINE = V_VISIBLE_LINES,
    parameter logic [9:0] FRAME_END_LINE   = V_TOTAL_LINES,
    parameter logic [9:0] GUARD_LINES      = 10'd2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [9:0]         Y_PIXEL,
    input  logic               FRAME_START,
    input  logic [NUM_REQ-1:0] REQ,
    input  logic [NUM_REQ-1:0] DONE,
    output logic [NUM_REQ-1:0] GRANT,
    output logic               BUSY,
    output logic               WINDOW_OPEN,
    output logic               OVERRUN,
    output logic [NUM_REQ-1:0] MISSED
);

    localparam int         PW         = $clog2(NUM_REQ);
    localparam logic [9:0] CLOSE_LINE = FRAME_END_LINE - GUARD_LINES;

    sched_state_t       state, state_nxt;
    logic [NUM_REQ-1:0] served, served_nxt, seen;
    logic [NUM_REQ-1:0] grant_nxt, eligible, winner;
    logic [PW-1:0]      ptr, ptr_inc;
    logic               win_vld, overrun_nxt, release_hit, window_nxt;

    assign eligible    = REQ & ~served;
    assign release_hit = |(DONE & GRANT);
    assign window_nxt  = (Y_PIXEL >= VISIBLE_END_LINE) && (Y_PIXEL < CLOSE_LINE);
    assign ptr_inc     = (ptr == PW'(NUM_REQ - 1)) ? '0 : ptr + 1'b1;

    round_robin_picker #(.N(NUM_REQ), .PW(PW)) u_picker (
        .eligible (eligible),
        .ptr      (ptr),
        .winner   (winner),
        .valid    (win_vld)
    );

    always_comb begin
        state_nxt   = state;
        grant_nxt   = GRANT;
        served_nxt  = served;
        overrun_nxt = 1'b0;
        case (state)
            ST_WAIT: begin
                if (WINDOW_OPEN) begin
                    state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (!WINDOW_OPEN) begin
                    state_nxt = ST_WAIT;
                // No grant on the frame-start cycle: served is being cleared.
                end else if (win_vld && !FRAME_START) begin
                    grant_nxt  = winner;
                    served_nxt = served | winner;
                    state_nxt  = ST_GRANTED;
                end
            end
            ST_GRANTED: begin
                // A release on the closing edge wins over the revoke.
                if (release_hit) begin
                    grant_nxt = '0;
                    state_nxt = ST_ARB;
                end else if (!WINDOW_OPEN) begin
                    grant_nxt   = '0;
                    overrun_nxt = 1'b1;
                    state_nxt   = ST_WAIT;
                end
            end
            default: begin
                grant_nxt = '0;
                state_nxt = ST_WAIT;
            end
        endcase
        // Only reachable if the guard band is misconfigured.
        if (FRAME_START && state == ST_GRANTED) begin
            grant_nxt   = '0;
            overrun_nxt = 1'b1;
            state_nxt   = ST_WAIT;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= ST_WAIT;
            GRANT       <= '0;
            BUSY        <= 1'b0;
            WINDOW_OPEN <= 1'b0;
            OVERRUN     <= 1'b0;
            MISSED      <= '0;
            served      <= '0;
            seen        <= '0;
            ptr         <= '0;
        end else begin
            state       <= state_nxt;
            GRANT       <= grant_nxt;
            BUSY        <= |grant_nxt;
            WINDOW_OPEN <= window_nxt;
            OVERRUN     <= overrun_nxt;
            if (FRAME_START) begin
                MISSED <= seen & ~served;
                served <= '0;
                seen   <= '0;
                ptr    <= ptr_inc;
            end else begin
                served <= served_nxt;
                seen   <= seen | (REQ & {NUM_REQ{WINDOW_OPEN}});
            end
        end
    end

endmodule

// File: tb/tb_vblank_access_scheduler.sv
// Directed bench for vblank_access_scheduler: scenario tasks with inline checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_vblank_access_scheduler;

    localparam int N  = 4;
    localparam int BL = 4;   // cycles per blanking line

    logic         CLK = 1'b0;
    logic         RESET;
    logic [9:0]   Y_PIXEL;
    logic         FRAME_START;
    logic [N-1:0] REQ;
    logic [N-1:0] DONE;
    logic [N-1:0] GRANT;
    logic         BUSY;
    logic         WINDOW_OPEN;
    logic         OVERRUN;
    logic [N-1:0] MISSED;

    vblank_access_scheduler #(.NUM_REQ(N)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Y_PIXEL     (Y_PIXEL),
        .FRAME_START (FRAME_START),
        .REQ         (REQ),
        .DONE        (DONE),
        .GRANT       (GRANT),
        .BUSY        (BUSY),
        .WINDOW_OPEN (WINDOW_OPEN),
        .OVERRUN     (OVERRUN),
        .MISSED      (MISSED)
    );

    initial forever #5 CLK = ~CLK;

    int cyc_cnt = 0;
    always @(posedge CLK) cyc_cnt <= cyc_cnt + 1;

    int tests = 0;
    int fails = 0;

    // Monitor / DONE responder state.
    int           g_idx[$];
    int           g_cyc[$];
    int           rel_cyc[$];
    int           line_cyc[0:627];
    int           win_cnt, win_rise, win_fall, ovr_cnt, ovr_cyc, busy_err;
    int           done_timer;
    logic [N-1:0] ovr_grant, done_tgt, auto_val, manual_done, no_done;
    logic [N-1:0] prev_grant;
    logic         prev_win, auto_done;

    function automatic int oh_idx(input logic [N-1:0] v);
        int r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Samples on the falling edge; DONE is driven here so it is stable at posedge.
    initial begin
        prev_grant = '0;
        prev_win   = 1'b0;
        forever begin
            @(negedge CLK);
            auto_val = '0;
            if (BUSY !== (|GRANT)) busy_err++;
            if (WINDOW_OPEN === 1'b1) win_cnt++;
            if (WINDOW_OPEN === 1'b1 && prev_win !== 1'b1) win_rise = cyc_cnt;
            if (WINDOW_OPEN === 1'b0 && prev_win === 1'b1) win_fall = cyc_cnt;
            if (OVERRUN === 1'b1) begin
                ovr_cnt++;
                ovr_cyc   = cyc_cnt;
                ovr_grant = GRANT;
            end
            if (done_timer > 0) begin
                done_timer--;
                if (done_timer == 0) auto_val = done_tgt;
            end
            if (GRANT != '0 && prev_grant == '0) begin
                g_idx.push_back(oh_idx(GRANT));
                g_cyc.push_back(cyc_cnt);
                if ((GRANT & no_done) == '0) begin
                    done_tgt   = GRANT;
                    done_timer = 10;
                end
            end else if (GRANT == '0 && prev_grant != '0) begin
                rel_cyc.push_back(cyc_cnt);
            end
            DONE       = auto_done ? auto_val : manual_done;
            prev_grant = GRANT;
            prev_win   = WINDOW_OPEN;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        g_idx.delete();
        g_cyc.delete();
        rel_cyc.delete();
        win_cnt = 0; win_rise = -1; win_fall = -1;
        ovr_cnt = 0; ovr_cyc = -1; ovr_grant = '0;
        busy_err = 0; done_timer = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        FRAME_START = 1'b0;
        Y_PIXEL = '0;
        repeat (3) step();
        RESET = 1'b0;
        clear_logs();
    endtask

    task automatic drive_line(input int y, input int n, input bit pulse);
        Y_PIXEL     = 10'(y);
        FRAME_START = pulse;
        line_cyc[y] = cyc_cnt;
        for (int i = 0; i < n; i++) begin
            step();
            FRAME_START = 1'b0;
        end
    endtask

    task automatic drive_frame(input bit pulse, input int last);
        for (int y = 0; y <= last; y++)
            drive_line(y, (y < 600) ? 1 : BL, pulse && (y == 0));
    endtask

    task automatic check_order(input string nm, input int exp[4], input int n);
        tests++;
        if (g_idx.size() != n) begin
            fails++;
            $display("FAIL %s_count: got %0d grants, required %0d", nm, g_idx.size(), n);
        end
        for (int i = 0; i < n && i < g_idx.size(); i++) begin
            tests++;
            if (g_idx[i] !== exp[i]) begin
                fails++;
                $display("FAIL %s_order[%0d]: got %0d, required %0d", nm, i, g_idx[i], exp[i]);
            end
        end
        for (int i = 1; i < n && i < g_idx.size(); i++) begin
            tests++;
            // 10-cycle hold, 1 cycle to release, 1 idle cycle, then next grant.
            if (g_cyc[i] - g_cyc[i-1] != 12 || rel_cyc[i-1] != g_cyc[i] - 1) begin
                fails++;
                $display("FAIL %s_gap[%0d]: got spacing %0d, required 12", nm, i,
                         g_cyc[i] - g_cyc[i-1]);
            end
        end
    endtask

    task automatic test_reset();
        REQ = '0; manual_done = '0; auto_done = 1'b1; no_done = '0;
        do_reset();
        tests++;
        if ({GRANT, BUSY, WINDOW_OPEN, OVERRUN, MISSED} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got G=%b B=%b W=%b O=%b M=%b, required all 0",
                     GRANT, BUSY, WINDOW_OPEN, OVERRUN, MISSED);
        end
    endtask

    task automatic test_idle_frame();
        do_reset();
        REQ = '0;
        drive_frame(1'b0, 627);
        drive_line(0, 2, 1'b1);
        tests++;
        if (g_idx.size() != 0) begin
            fails++; $display("FAIL idle_grants: got %0d, required 0", g_idx.size());
        end
        tests++;
        if (win_cnt != 26 * BL) begin
            fails++; $display("FAIL idle_win_len: got %0d, required %0d", win_cnt, 26 * BL);
        end
        tests++;
        if (win_rise != line_cyc[600] + 1) begin
            fails++; $display("FAIL idle_win_rise: got %0d, required %0d", win_rise, line_cyc[600] + 1);
        end
        tests++;
        if (win_fall != line_cyc[626] + 1) begin
            fails++; $display("FAIL idle_win_fall: got %0d, required %0d", win_fall, line_cyc[626] + 1);
        end
        tests++;
        if (MISSED !== 4'b0000) begin
            fails++; $display("FAIL idle_missed: got %b, required 0000", MISSED);
        end
    endtask

    task automatic test_round_robin();
        int exp[4] = '{0, 1, 2, 3};
        do_reset();
        REQ = 4'b1111;
        drive_frame(1'b0, 627);
        check_order("rr1", exp, 4);
        tests++;
        if (g_cyc.size() > 0 && g_cyc[0] != line_cyc[600] + 3) begin
            fails++; $display("FAIL rr1_first: got %0d, required %0d", g_cyc[0], line_cyc[600] + 3);
        end
        tests++;
        if (busy_err != 0) begin
            fails++; $display("FAIL rr1_busy: got %0d BUSY errors, required 0", busy_err);
        end
    endtask

    task automatic test_second_frame();
        int exp[4] = '{1, 2, 3, 0};
        clear_logs();
        drive_frame(1'b1, 627);
        check_order("rr2", exp, 4);
        tests++;
        if (MISSED !== 4'b0000) begin
            fails++; $display("FAIL rr2_missed: got %b, required 0000", MISSED);
        end
    endtask

    task automatic test_overrun();
        int exp[4] = '{0, 1, 2, 0};
        do_reset();
        REQ = 4'b1111;
        no_done = 4'b0100;
        drive_frame(1'b0, 627);
        check_order("ovr", exp, 3);
        tests++;
        if (ovr_cnt != 1 || ovr_cyc != line_cyc[626] + 2 || ovr_grant !== 4'b0000) begin
            fails++;
            $display("FAIL ovr_pulse: got cnt=%0d cyc=%0d grant=%b, required 1/%0d/0000",
                     ovr_cnt, ovr_cyc, ovr_grant, line_cyc[626] + 2);
        end
        drive_frame(1'b1, 3);
        tests++;
        if (MISSED !== 4'b1000) begin
            fails++; $display("FAIL ovr_missed: got %b, required 1000", MISSED);
        end
        tests++;
        if (g_idx.size() != 3 || ovr_cnt != 1) begin
            fails++;
            $display("FAIL ovr_after: got grants=%0d overruns=%0d, required 3/1", g_idx.size(), ovr_cnt);
        end
        no_done = '0;
    endtask

    task automatic test_done_at_close();
        do_reset();
        auto_done = 1'b0;
        REQ = 4'b0001;
        drive_frame(1'b0, 625);
        Y_PIXEL = 10'd626;
        step();
        tests++;
        if (GRANT !== 4'b0001 || WINDOW_OPEN !== 1'b0) begin
            fails++;
            $display("FAIL close_pre: got G=%b W=%b, required 0001/0", GRANT, WINDOW_OPEN);
        end
        manual_done = 4'b0001;
        step();
        manual_done = '0;
        tests++;
        if (GRANT !== 4'b0000 || OVERRUN !== 1'b0) begin
            fails++;
            $display("FAIL close_release: got G=%b O=%b, required 0000/0", GRANT, OVERRUN);
        end
        repeat (3) step();
        tests++;
        if (ovr_cnt != 0) begin
            fails++; $display("FAIL close_no_ovr: got %0d overruns, required 0", ovr_cnt);
        end
        auto_done = 1'b1;
    endtask

    task automatic test_visible_hold();
        do_reset();
        REQ = 4'b0010;
        drive_frame(1'b0, 599);
        drive_line(600, 3, 1'b0);
        step();
        tests++;
        if (g_idx.size() != 1 || g_cyc[0] != line_cyc[600] + 3 || g_idx[0] != 1) begin
            fails++;
            $display("FAIL vis_grant: got n=%0d, required one grant of 1 at %0d",
                     g_idx.size(), line_cyc[600] + 3);
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        tests++;
        if (GRANT !== 4'b0000 || BUSY !== 1'b0 || OVERRUN !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_grant: got G=%b B=%b O=%b, required 0000/0/0",
                     GRANT, BUSY, OVERRUN);
        end
    endtask

    initial begin
        test_reset();
        test_idle_frame();
        test_round_robin();
        test_second_frame();
        test_overrun();
        test_done_at_close();
        test_visible_hold();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
